// File: rtl/hex_pio_write_arbiter.sv
// hex_pio_write_arbiter
//   Shares the 8-bit HEX3..HEX0 PIO output register between two valid/ready
//   byte sources. Contention is settled round-robin. Each accepted byte is
//   written to the PIO as a single zero-wait-state Avalon-MM write. The
//   arbiter then waits HOLD_CYCLES idle cycles before it accepts another
//   byte, so every value stays on the display long enough to be seen.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   reqN_valid/data/ready     requester N byte handshake (ready is combinational)
//   m_address                 PIO slave address, always 2'b00
//   m_chipselect, m_write_n   PIO write qualifiers (one-cycle strobe)
//   m_writedata               {24'b0, latched byte}, driven in every state
//   busy                      high whenever the FSM is not IDLE
//   last_grant                index of the most recently accepted requester
module hex_pio_write_arbiter #(
    parameter int HOLD_CYCLES = 5000000,
    parameter int CNT_W       = 23
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy,
    output logic        last_grant
);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       wdata_q, wdata_nxt;
    logic             last_grant_q, last_grant_nxt;
    logic             grant;

    // Round-robin only matters under contention; a lone requester always
    // wins, even if it was also the last one served.
    always_comb begin
        if (req0_valid && req1_valid)
            grant = ~last_grant_q;
        else
            grant = req1_valid;
    end

    // reset_n gates ready so no handshake can be seen while reset is held.
    assign req0_ready = (state == IDLE) && reset_n && !grant && req0_valid;
    assign req1_ready = (state == IDLE) && reset_n &&  grant && req1_valid;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wdata_nxt      = wdata_q;
        last_grant_nxt = last_grant_q;
        case (state)
            IDLE: begin
                if (req0_ready) begin
                    wdata_nxt      = req0_data;
                    last_grant_nxt = 1'b0;
                    state_nxt      = WRITE;
                end else if (req1_ready) begin
                    wdata_nxt      = req1_data;
                    last_grant_nxt = 1'b1;
                    state_nxt      = WRITE;
                end
            end
            WRITE: begin
                // Counting HOLD_CYCLES-1 down to 0 inclusive gives exactly
                // HOLD_CYCLES cycles in HOLD.
                cnt_nxt   = HOLD_LOAD;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            wdata_q      <= wdata_nxt;
            last_grant_q <= last_grant_nxt;
        end
    end

    // The strobe is decoded straight from the state register, so a reset
    // during WRITE removes it at the same edge.
    assign m_address    = 2'b00;
    assign m_chipselect = (state == WRITE);
    assign m_write_n    = (state != WRITE);
    assign m_writedata  = {24'b0, wdata_q};
    assign busy         = (state != IDLE);
    assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_hex_pio_write_arbiter.sv
// Directed bench for hex_pio_write_arbiter with HOLD_CYCLES=4, which makes
// the accept-to-accept spacing 6 cycles. Inputs change 1 time unit after
// posedge. Outputs are sampled on negedge.
module tb_hex_pio_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [1:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [31:0] m_writedata;
    logic        busy, last_grant;

    hex_pio_write_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records write strobes and grants with cycle stamps.
    int          st_cyc[$];
    logic [31:0] st_data[$];
    int          gr_id[$];
    int          gr_cyc[$];
    bit          both_rdy = 1'b0;
    always @(negedge clk) begin
        if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
            st_cyc.push_back(cyc);
            st_data.push_back(m_writedata);
        end
        if (req0_ready === 1'b1) begin gr_id.push_back(0); gr_cyc.push_back(cyc); end
        if (req1_ready === 1'b1) begin gr_id.push_back(1); gr_cyc.push_back(cyc); end
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy = 1'b1;
    end

    // Byte queues feeding the requesters.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic clear_logs();
        st_cyc.delete(); st_data.delete(); gr_id.delete(); gr_cyc.delete();
    endtask

    // Presents queued bytes to the requesters and pops each one on its handshake.
    // It is entered and left 1 time unit after posedge.
    task automatic serve(input int budget, output bit done);
        bit a0, a1;
        logic [7:0] tmp;
        for (int k = 0; k < budget; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            req0_valid = (q0.size() != 0);
            if (q0.size() != 0) req0_data = q0[0];
            req1_valid = (q1.size() != 0);
            if (q1.size() != 0) req1_data = q1[0];
            @(negedge clk);
            a0 = req0_ready; a1 = req1_ready;
            @(posedge clk); #1;
            if (a0 && q0.size() != 0) tmp = q0.pop_front();
            if (a1 && q1.size() != 0) tmp = q1.pop_front();
        end
        done = (q0.size() == 0 && q1.size() == 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'hAA; req1_data = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin n_err++; $display("FAIL reset_strobe got cs=%0b wn=%0b want cs=0 wn=1", m_chipselect, m_write_n); end
        n_cmp++; if (m_writedata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 00000000", m_writedata); end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL reset_last_grant got %0b want 1", last_grant); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b%0b want 00", req0_ready, req1_ready); end
        n_cmp++; if (m_address !== 2'b00) begin n_err++; $display("FAIL reset_addr got %b want 00", m_address); end
        @(posedge clk); #1;
        reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // T1: single byte from req0.
    task automatic test_single();
        int c0;
        bit ok;
        clear_logs();
        req0_valid = 1'b1; req0_data = 8'h3F;
        @(negedge clk);
        c0 = cyc;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %0b want 1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0) begin n_err++; $display("FAIL single_strobe got cs=%0b wn=%0b want cs=1 wn=0", m_chipselect, m_write_n); end
        n_cmp++; if (m_writedata !== 32'h0000003F) begin n_err++; $display("FAIL single_wdata got %h want 0000003f", m_writedata); end
        n_cmp++; if (m_address !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL single_addr_busy got addr=%b busy=%0b want 00 1", m_address, busy); end
        n_cmp++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL single_last_grant got %0b want 0", last_grant); end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || cyc - c0 != 6) begin n_err++; $display("FAIL single_busy_release got %0d cycles (ok=%0b) want 6", cyc - c0, ok); end
        n_cmp++; if (st_cyc.size() != 1) begin n_err++; $display("FAIL single_strobe_count got %0d want 1", st_cyc.size()); end
        @(posedge clk); #1;
    endtask

    // T2: simultaneous requests straight after reset.
    task automatic test_contend();
        bit done, ok;
        clear_logs();
        q0 = '{8'h06}; q1 = '{8'h5B};
        serve(40, done);
        wait_idle(20, ok);
        n_cmp++; if (!done || !ok) begin n_err++; $display("FAIL contend_timeout got done=%0b idle=%0b want 1 1", done, ok); end
        n_cmp++; if (gr_id.size() != 2 || st_data.size() != 2) begin n_err++; $display("FAIL contend_count got grants=%0d strobes=%0d want 2 2", gr_id.size(), st_data.size()); end
        else begin
            n_cmp++; if (gr_id[0] != 0 || gr_id[1] != 1) begin n_err++; $display("FAIL contend_order got %0d,%0d want 0,1", gr_id[0], gr_id[1]); end
            n_cmp++; if (gr_cyc[1] - gr_cyc[0] != 6) begin n_err++; $display("FAIL contend_spacing got %0d want 6", gr_cyc[1] - gr_cyc[0]); end
            n_cmp++; if (st_data[0] !== 32'h06 || st_data[1] !== 32'h5B) begin n_err++; $display("FAIL contend_data got %h,%h want 00000006,0000005b", st_data[0], st_data[1]); end
            n_cmp++; if (st_cyc[0] != gr_cyc[0] + 1) begin n_err++; $display("FAIL contend_latency got %0d want 1", st_cyc[0] - gr_cyc[0]); end
        end
    endtask

    // T3: both requesters continuously valid for six transfers.
    task automatic test_back_to_back();
        bit done, ok;
        clear_logs();
        q0 = '{8'h10, 8'h12, 8'h14}; q1 = '{8'h11, 8'h13, 8'h15};
        serve(100, done);
        wait_idle(20, ok);
        n_cmp++; if (!done || !ok) begin n_err++; $display("FAIL b2b_timeout got done=%0b idle=%0b want 1 1", done, ok); end
        n_cmp++; if (gr_id.size() != 6 || st_data.size() != 6) begin n_err++; $display("FAIL b2b_count got grants=%0d strobes=%0d want 6 6", gr_id.size(), st_data.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (gr_id[i] != (i % 2)) begin n_err++; $display("FAIL b2b_grant[%0d] got %0d want %0d", i, gr_id[i], i % 2); end
                n_cmp++; if (st_data[i] !== 32'(8'h10 + i)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, st_data[i], 32'(8'h10 + i)); end
                if (i > 0) begin
                    n_cmp++; if (st_cyc[i] - st_cyc[i-1] != 6) begin n_err++; $display("FAIL b2b_spacing[%0d] got %0d want 6", i, st_cyc[i] - st_cyc[i-1]); end
                end
            end
        end
        n_cmp++; if (both_rdy) begin n_err++; $display("FAIL b2b_both_ready got 1 want 0"); end
    endtask

    // T4: uncontended requester 1 granted repeatedly.
    task automatic test_solo_req1();
        bit done, ok;
        clear_logs();
        q1 = '{8'h66, 8'h6D, 8'h7D};
        serve(60, done);
        wait_idle(20, ok);
        n_cmp++; if (!done || !ok) begin n_err++; $display("FAIL solo_timeout got done=%0b idle=%0b want 1 1", done, ok); end
        n_cmp++; if (gr_id.size() != 3 || st_data.size() != 3) begin n_err++; $display("FAIL solo_count got grants=%0d strobes=%0d want 3 3", gr_id.size(), st_data.size()); end
        else begin
            n_cmp++; if (gr_id[0] != 1 || gr_id[1] != 1 || gr_id[2] != 1) begin n_err++; $display("FAIL solo_grants got %0d%0d%0d want 111", gr_id[0], gr_id[1], gr_id[2]); end
            n_cmp++; if (st_data[0] !== 32'h66 || st_data[1] !== 32'h6D || st_data[2] !== 32'h7D) begin n_err++; $display("FAIL solo_data got %h,%h,%h want 66,6d,7d", st_data[0], st_data[1], st_data[2]); end
            n_cmp++; if (st_cyc[1] - st_cyc[0] != 6 || st_cyc[2] - st_cyc[1] != 6) begin n_err++; $display("FAIL solo_spacing got %0d,%0d want 6,6", st_cyc[1] - st_cyc[0], st_cyc[2] - st_cyc[1]); end
        end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL solo_last_grant got %0b want 1", last_grant); end
    endtask

    // T5: one-cycle reset while the hold counter is at 2.
    task automatic test_reset_mid_hold();
        bit done, ok;
        clear_logs();
        q0 = '{8'h4F};
        serve(20, done);              // leaves us in the WRITE cycle
        @(posedge clk); #1;           // HOLD, counter 3
        @(posedge clk); #1;           // HOLD, counter 2
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h77;
        req1_valid = 1'b1; req1_data = 8'h88;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || m_chipselect !== 1'b0 || m_writedata !== 32'h0) begin n_err++; $display("FAIL midhold_reset got busy=%0b cs=%0b wdata=%h want 0 0 00000000", busy, m_chipselect, m_writedata); end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL midhold_last_grant got %0b want 1", last_grant); end
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL midhold_rearb got %0b%0b want 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(20, ok);
        n_cmp++; if (!done || !ok) begin n_err++; $display("FAIL midhold_timeout got done=%0b idle=%0b want 1 1", done, ok); end
        n_cmp++; if (st_data.size() != 2) begin n_err++; $display("FAIL midhold_strobes got %0d want 2", st_data.size()); end
        else begin
            n_cmp++; if (st_data[1] !== 32'h77) begin n_err++; $display("FAIL midhold_data got %h want 00000077", st_data[1]); end
        end
    endtask

    // T6: a valid pulse during HOLD that is withdrawn before it can be accepted.
    task automatic test_valid_drop();
        bit done, ok;
        clear_logs();
        q0 = '{8'h4F};
        serve(20, done);
        @(posedge clk); #1;           // HOLD
        req0_valid = 1'b1; req0_data = 8'h99;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready got %0b want 0", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_idle(20, ok);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (!done || !ok) begin n_err++; $display("FAIL drop_timeout got done=%0b idle=%0b want 1 1", done, ok); end
        n_cmp++; if (st_data.size() != 1 || gr_id.size() != 1) begin n_err++; $display("FAIL drop_count got strobes=%0d grants=%0d want 1 1", st_data.size(), gr_id.size()); end
        n_cmp++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL drop_last_grant got %0b want 0", last_grant); end
        n_cmp++; if (m_writedata !== 32'h4F) begin n_err++; $display("FAIL drop_wdata got %h want 0000004f", m_writedata); end
    endtask

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_reset();
        test_contend();
        test_back_to_back();
        test_solo_req1();
        test_reset_mid_hold();
        test_valid_drop();
        n_cmp++; if (both_rdy) begin n_err++; $display("FAIL never_both_ready got 1 want 0"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
